// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// The head register drives the outputs; the skid register absorbs one beat while downstream stalls.
module pipe_stage_skid #(
    parameter int CTRL_W = 3,
    parameter int RD_W   = 5,
    parameter int DATA_W = 64,
    parameter int NDATA  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CTRL_W-1:0]       in_ctrl,
    input  logic [RD_W-1:0]         in_rd,
    input  logic [NDATA*DATA_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CTRL_W-1:0]       out_ctrl,
    output logic [RD_W-1:0]         out_rd,
    output logic [NDATA*DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]        stall_cnt,
    output logic [CNT_W-1:0]        bubble_cnt
);

    localparam int DW = NDATA * DATA_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    state_e            r_state;
    state_e            w_state_nxt;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [CTRL_W-1:0] r_head_ctrl;
    logic [RD_W-1:0]   r_head_rd;
    logic [DW-1:0]     r_head_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [RD_W-1:0]   r_skid_rd;
    logic [DW-1:0]     r_skid_data;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_bubble_cnt;
    logic              w_accept;
    logic              w_emit;
    logic              w_load_head_in;
    logic              w_load_head_skid;
    logic              w_load_skid;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic hit);
        if (hit && !(&v)) begin
            sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            sat_inc = v;
        end
    endfunction

    assign w_accept = in_valid & r_in_ready;
    assign w_emit   = r_out_valid & out_ready;

    // Occupancy state register; in_ready/out_valid are registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt != ST_TWO);
            r_out_valid <= (w_state_nxt != ST_EMPTY);
        end
    end

    // Next-state logic; flush squashes everything including a same-cycle accept.
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = ST_ONE;
                    end else begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (w_accept && !w_emit) begin
                        w_state_nxt = ST_TWO;
                    end else if (!w_accept && w_emit) begin
                        w_state_nxt = ST_EMPTY;
                    end else begin
                        w_state_nxt = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (w_emit) begin
                        w_state_nxt = ST_ONE;
                    end else begin
                        w_state_nxt = ST_TWO;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    // Storage load enables decoded from occupancy and handshake.
    always_comb begin
        w_load_head_in   = 1'b0;
        w_load_head_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_load_head_in = 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: w_load_head_in = w_accept;
                ST_ONE: begin
                    w_load_head_in = w_accept & w_emit;
                    w_load_skid    = w_accept & ~w_emit;
                end
                ST_TWO:   w_load_head_skid = w_emit;
                default:  w_load_head_in = 1'b0;
            endcase
        end
    end

    // Head and skid data registers; the head holds its value when the stage drains or flushes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head_ctrl <= {CTRL_W{1'b0}};
            r_head_rd   <= {RD_W{1'b0}};
            r_head_data <= {DW{1'b0}};
            r_skid_ctrl <= {CTRL_W{1'b0}};
            r_skid_rd   <= {RD_W{1'b0}};
            r_skid_data <= {DW{1'b0}};
        end else begin
            if (w_load_head_in) begin
                r_head_ctrl <= in_ctrl;
                r_head_rd   <= in_rd;
                r_head_data <= in_data;
            end else if (w_load_head_skid) begin
                r_head_ctrl <= r_skid_ctrl;
                r_head_rd   <= r_skid_rd;
                r_head_data <= r_skid_data;
            end
            if (w_load_skid) begin
                r_skid_ctrl <= in_ctrl;
                r_skid_rd   <= in_rd;
                r_skid_data <= in_data;
            end
        end
    end

    // Saturating stall/bubble counters on the pre-edge handshake; flush leaves them alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt  <= {CNT_W{1'b0}};
            r_bubble_cnt <= {CNT_W{1'b0}};
        end else begin
            r_stall_cnt  <= sat_inc(r_stall_cnt, r_out_valid & ~out_ready);
            r_bubble_cnt <= sat_inc(r_bubble_cnt, ~r_out_valid & out_ready);
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_ctrl   = r_out_valid ? r_head_ctrl : {CTRL_W{1'b0}};
    assign out_rd     = r_out_valid ? r_head_rd : {RD_W{1'b0}};
    assign out_data   = r_head_data;
    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;

endmodule
